// File: rtl/apb_requester_arbiter.sv
// APB requester: round-robin arbitration of NUM_REQ command sources onto one IDLE/SETUP/ACCESS bus.
// Optional ACCESS wait-state timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_requester_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           pclk,
  input  logic                           presetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           psel,
  output logic                           penable,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic                           pwrite,
  output logic [DATA_WIDTH-1:0]          pwdata,
  input  logic                           pready,
  input  logic [DATA_WIDTH-1:0]          prdata,
  input  logic                           pslverr
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]            state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      owner;
  logic [PTR_W-1:0]      scan_idx;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      gnt_next;
  logic                  gnt_found;
  logic                  gnt_write;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic                  arb_en;

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;
`else
  // Parameter kept so both builds share one instantiation signature.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // First valid source at or above the RR pointer, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_next  = '0;
    gnt_write = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
        gnt_next  = PTR_W'((int'(scan_idx) + 1) % NUM_REQ);
        gnt_write = req_write[scan_idx];
        gnt_addr  = req_addr[scan_idx*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_wdata = req_write[scan_idx] ? req_wdata[scan_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
    end
  end

  assign arb_en = presetn && ((state == ST_IDLE) || ((state == ST_ACCESS) && pready));

  always_comb begin
    req_ready = '0;
    if (arb_en && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign psel    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign penable = (state == ST_ACCESS);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      // A grant in IDLE or in the completing ACCESS cycle starts the next SETUP.
      if (arb_en && gnt_found) begin
        owner  <= gnt_idx;
        rr_ptr <= gnt_next;
        paddr  <= gnt_addr;
        pwrite <= gnt_write;
        pwdata <= gnt_wdata;
      end
      case (state)
        ST_IDLE: begin
          if (gnt_found) state <= ST_SETUP;
        end
        ST_SETUP: begin
          state <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_ACCESS: begin
          if (pready) begin
            rsp_valid[owner] <= 1'b1;
            rsp_err          <= pslverr;
            rsp_rdata        <= pwrite ? '0 : prdata;
            state            <= gnt_found ? ST_SETUP : ST_IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid[owner] <= 1'b1;
            rsp_err          <= 1'b1;
            rsp_rdata        <= '0;
            state            <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
